// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 64-bit memory port: instruction fetch vs data access.
// Holds one grant until ram_ready or timeout, with alternating priority when both request.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_load,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  output logic [DATA_W-1:0] d_load,
  output logic              d_done,
  output logic              d_err,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [1:0]        ram_size_q, ram_size_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;

  logic d_any;
  logic pick_d;
  logic timeout_hit;
  logic finish;

  assign d_any       = d_ren | d_wen;
  assign pick_d      = d_any & (~i_req | ~last_d_q);
  assign timeout_hit = (state_q != IDLE) & ~ram_ready & (cnt_q == CNT_LAST);
  assign finish      = ram_ready | timeout_hit;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_size_d  = ram_size_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        if (pick_d) begin
          // A simultaneous read and write is resolved as a write.
          state_d     = GRANT_D;
          ram_ren_d   = d_ren & ~d_wen;
          ram_wen_d   = d_wen;
          ram_size_d  = d_size;
          ram_addr_d  = d_addr;
          ram_store_d = d_wen ? d_store : '0;
        end else if (i_req) begin
          state_d     = GRANT_I;
          ram_ren_d   = 1'b1;
          ram_size_d  = 2'b11;
          ram_addr_d  = i_addr;
          ram_store_d = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (finish) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          last_d_d  = (state_q == GRANT_D);
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_size_q  <= '0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_size_q  <= ram_size_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
    end
  end

  // Completion pulses are suppressed while reset is asserted.
  assign i_done = ~rst & (state_q == GRANT_I) & ram_ready;
  assign i_err  = ~rst & (state_q == GRANT_I) & timeout_hit;
  assign d_done = ~rst & (state_q == GRANT_D) & ram_ready;
  assign d_err  = ~rst & (state_q == GRANT_D) & timeout_hit;
  assign i_load = i_done ? ram_load : '0;
  assign d_load = d_done ? ram_load : '0;

  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_size  = ram_size_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;

endmodule
